if_id_hazard_stage: RTL and testbench

IF_ID_HAZARD_STAGE -- requirements
Module: if_id_hazard_stage

---
 rtl/if_id_hazard_stage.sv | 109 ++++++++++
 tb/tb_if_id_hazard_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with load-use hazard detection, branch flush and event counters.
// flush_i beats a load-use hazard; a stall holds the PC and the IF/ID register.

module if_id_hazard_stage #(
   parameter logic [31:0] NOP = 32'h00000013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_i,
   input  logic [31:0] pc_4_i,
   input  logic [31:0] instruction_i,
   input  logic        instr_valid_i,
   input  logic        flush_i,
   input  logic        ID_EX_mem_read_i,
   input  logic [4:0]  ID_EX_write_register_i,
   output logic [31:0] IF_ID_pc_o,
   output logic [31:0] IF_ID_pc_4_o,
   output logic [31:0] IF_ID_instruction_o,
   output logic        IF_ID_valid_o,
   output logic        pc_write_o,
   output logic        ID_EX_bubble_o,
   output logic [1:0]  state_o,
   output logic [15:0] stall_cnt_o,
   output logic [15:0] flush_cnt_o
);

   typedef enum logic [1:0] {
      StRun   = 2'd0,
      StStall = 2'd1,
      StFlush = 2'd2
   } state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] pc_4_q;
   logic [31:0] instr_q;
   logic        valid_q;
   logic [15:0] stall_cnt_q;
   logic [15:0] flush_cnt_q;

   logic [4:0] rs1;
   logic [4:0] rs2;
   logic [6:0] opcode;
   logic       uses_rs2;
   logic       hazard;
   logic       stall;

   always_comb begin
      rs1    = instr_q[19:15];
      rs2    = instr_q[24:20];
      opcode = instr_q[6:0];
      // Only R-type, store and branch read rs2; I-type immediates alias the rs2 field.
      uses_rs2 = (opcode == 7'b0110011) || (opcode == 7'b0100011) || (opcode == 7'b1100011);
      hazard   = ID_EX_mem_read_i && valid_q && (ID_EX_write_register_i != 5'd0) &&
                 ((ID_EX_write_register_i == rs1) ||
                  (uses_rs2 && (ID_EX_write_register_i == rs2)));
      stall    = hazard && !flush_i;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StRun;
         pc_q        <= 32'd0;
         pc_4_q      <= 32'd0;
         instr_q     <= 32'd0;
         valid_q     <= 1'b0;
         stall_cnt_q <= 16'd0;
         flush_cnt_q <= 16'd0;
      end else begin
         if (flush_i) begin
            instr_q <= NOP;
            valid_q <= 1'b0;
         end else if (!stall) begin
            pc_q    <= pc_i;
            pc_4_q  <= pc_4_i;
            valid_q <= instr_valid_i;
            instr_q <= instr_valid_i ? instruction_i : NOP;
         end

         if (flush_i) begin
            state_q <= StFlush;
         end else if (hazard) begin
            state_q <= StStall;
         end else begin
            state_q <= StRun;
         end

         if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
         if (flush_i && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
         end
      end
   end

   always_comb begin
      IF_ID_pc_o          = pc_q;
      IF_ID_pc_4_o        = pc_4_q;
      IF_ID_instruction_o = instr_q;
      IF_ID_valid_o       = valid_q;
      pc_write_o          = !stall;
      ID_EX_bubble_o      = hazard || flush_i || !valid_q;
      state_o             = state_q;
      stall_cnt_o         = stall_cnt_q;
      flush_cnt_o         = flush_cnt_q;
   end

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Randomized and directed bench for if_id_hazard_stage against an arithmetic reference model.

module tb_if_id_hazard_stage;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk;
   logic        reset;
   logic [31:0] pc_i;
   logic [31:0] pc_4_i;
   logic [31:0] instruction_i;
   logic        instr_valid_i;
   logic        flush_i;
   logic        ID_EX_mem_read_i;
   logic [4:0]  ID_EX_write_register_i;
   logic [31:0] IF_ID_pc_o;
   logic [31:0] IF_ID_pc_4_o;
   logic [31:0] IF_ID_instruction_o;
   logic        IF_ID_valid_o;
   logic        pc_write_o;
   logic        ID_EX_bubble_o;
   logic [1:0]  state_o;
   logic [15:0] stall_cnt_o;
   logic [15:0] flush_cnt_o;

   if_id_hazard_stage #(.NOP(NOP)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .pc_i                   (pc_i),
      .pc_4_i                 (pc_4_i),
      .instruction_i          (instruction_i),
      .instr_valid_i          (instr_valid_i),
      .flush_i                (flush_i),
      .ID_EX_mem_read_i       (ID_EX_mem_read_i),
      .ID_EX_write_register_i (ID_EX_write_register_i),
      .IF_ID_pc_o             (IF_ID_pc_o),
      .IF_ID_pc_4_o           (IF_ID_pc_4_o),
      .IF_ID_instruction_o    (IF_ID_instruction_o),
      .IF_ID_valid_o          (IF_ID_valid_o),
      .pc_write_o             (pc_write_o),
      .ID_EX_bubble_o         (ID_EX_bubble_o),
      .state_o                (state_o),
      .stall_cnt_o            (stall_cnt_o),
      .flush_cnt_o            (flush_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests;
   int n_fail;

   // Reference model state, kept as plain integers.
   int unsigned m_pc, m_pc4, m_ins, m_valid, m_state, m_stall_cnt, m_flush_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_hazard();
      int unsigned rs1, rs2, op, rd;
      bit use2;
      rs1  = (m_ins >> 15) % 32;
      rs2  = (m_ins >> 20) % 32;
      op   = m_ins % 128;
      rd   = ID_EX_write_register_i;
      use2 = (op == 51) || (op == 35) || (op == 99);
      return ID_EX_mem_read_i && (m_valid != 0) && (rd != 0) &&
             ((rd == rs1) || (use2 && (rd == rs2)));
   endfunction

   task automatic model_reset();
      m_pc = 0; m_pc4 = 0; m_ins = 0; m_valid = 0; m_state = 0;
      m_stall_cnt = 0; m_flush_cnt = 0;
   endtask

   task automatic check_regs(input string pfx);
      check({pfx, ".pc"},    IF_ID_pc_o, m_pc);
      check({pfx, ".pc4"},   IF_ID_pc_4_o, m_pc4);
      check({pfx, ".ins"},   IF_ID_instruction_o, m_ins);
      check({pfx, ".valid"}, {31'd0, IF_ID_valid_o}, m_valid);
      check({pfx, ".state"}, {30'd0, state_o}, m_state);
      check({pfx, ".stcnt"}, {16'd0, stall_cnt_o}, m_stall_cnt);
      check({pfx, ".flcnt"}, {16'd0, flush_cnt_o}, m_flush_cnt);
   endtask

   // One clock: checks combinational outputs, advances model, checks registered outputs.
   task automatic step(input string pfx);
      bit hz, st;
      #1;
      hz = model_hazard();
      st = hz && !flush_i;
      check({pfx, ".pcw"},    {31'd0, pc_write_o}, {31'd0, !st});
      check({pfx, ".bubble"}, {31'd0, ID_EX_bubble_o}, {31'd0, hz || flush_i || (m_valid == 0)});
      @(posedge clk);
      if (flush_i) begin
         m_ins = NOP; m_valid = 0;
      end else if (!st) begin
         m_pc = pc_i; m_pc4 = pc_4_i; m_valid = instr_valid_i;
         m_ins = instr_valid_i ? instruction_i : NOP;
      end
      m_state = flush_i ? 2 : (hz ? 1 : 0);
      if (st && m_stall_cnt < 65535) m_stall_cnt++;
      if (flush_i && m_flush_cnt < 65535) m_flush_cnt++;
      #1;
      check_regs(pfx);
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input bit v, input bit fl,
                        input bit mr, input logic [4:0] rd);
      pc_i = pc; pc_4_i = pc + 32'd4; instruction_i = ins; instr_valid_i = v;
      flush_i = fl; ID_EX_mem_read_i = mr; ID_EX_write_register_i = rd;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      model_reset();
      check_regs("rst");
      check("rst.pcw", {31'd0, pc_write_o}, 32'd1);
      check("rst.bubble", {31'd0, ID_EX_bubble_o}, 32'd1);
      @(posedge clk);
      #3 reset = 1'b0;
   endtask

   int unsigned ops [5] = '{51, 35, 99, 19, 3};

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b0;
      drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
      model_reset();
      apply_reset();

      // Basic load.
      drive(32'h100, 32'h00A58533, 1'b1, 1'b0, 1'b0, 5'd0);
      step("load");
      check("load.ins_k", IF_ID_instruction_o, 32'h00A58533);
      check("load.pc4_k", IF_ID_pc_4_o, 32'h104);
      check("load.bub_k", {31'd0, ID_EX_bubble_o}, 32'd0);

      // Load-use on rs2 of an R-type: hold one edge.
      drive(32'h200, 32'h11111111, 1'b1, 1'b0, 1'b1, 5'd10);
      step("lu");
      check("lu.pc_k", IF_ID_pc_o, 32'h100);
      check("lu.stcnt_k", {16'd0, stall_cnt_o}, 32'd1);
      check("lu.state_k", {30'd0, state_o}, 32'd1);

      // rd = 0 never stalls.
      drive(32'h108, 32'h00A58513, 1'b1, 1'b0, 1'b1, 5'd0);
      step("rd0");
      check("rd0.pc_k", IF_ID_pc_o, 32'h108);
      // I-type: rd matches imm field only.
      drive(32'h10C, 32'h00A58533, 1'b1, 1'b0, 1'b1, 5'd10);
      step("itype");
      check("itype.pc_k", IF_ID_pc_o, 32'h10C);

      // Flush with a pending hazard counts only as a flush.
      drive(32'h300, 32'h22222222, 1'b1, 1'b1, 1'b1, 5'd10);
      step("flhz");
      check("flhz.ins_k", IF_ID_instruction_o, NOP);
      check("flhz.flcnt_k", {16'd0, flush_cnt_o}, 32'd1);
      check("flhz.stcnt_k", {16'd0, stall_cnt_o}, 32'd1);
      check("flhz.pc_k", IF_ID_pc_o, 32'h10C);

      // Invalid fetch becomes a NOP bubble.
      drive(32'h400, 32'h33333333, 1'b0, 1'b0, 1'b0, 5'd0);
      step("inv");
      check("inv.ins_k", IF_ID_instruction_o, NOP);
      #1 check("inv.bub_k", {31'd0, ID_EX_bubble_o}, 32'd1);

      // Randomized traffic, biased toward hazards.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] ins;
         logic [4:0]  rd;
         ins = ($urandom & 32'hFFFF_FF80) | ops[$urandom_range(0, 4)];
         case ($urandom_range(0, 3))
            0: rd = 5'((m_ins >> 15) % 32);
            1: rd = 5'((m_ins >> 20) % 32);
            2: rd = 5'($urandom_range(0, 31));
            default: rd = 5'd0;
         endcase
         drive($urandom, ins, ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 1) == 1), rd);
         step("rnd");
      end

      // Saturate the stall counter with a held hazard, then reset mid-stall.
      apply_reset();
      drive(32'h100, 32'h00A58533, 1'b1, 1'b0, 1'b0, 5'd0);
      step("sat.ld");
      drive(32'h500, 32'h44444444, 1'b1, 1'b0, 1'b1, 5'd11);
      repeat (65540) @(posedge clk);
      #1;
      m_stall_cnt = 65535;
      m_state = 1;
      check("sat.stcnt_k", {16'd0, stall_cnt_o}, 32'h0000FFFF);
      check_regs("sat");
      @(negedge clk);
      step("sat.hold");
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_regs("amid");
      check("amid.pcw", {31'd0, pc_write_o}, 32'd1);
      #4 reset = 1'b0;
      drive(32'h600, 32'h00B50533, 1'b1, 1'b0, 1'b0, 5'd0);
      step("post");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
